// File: rtl/vector_alu_seq.sv
// rtl/vector_alu_seq.sv - multi-cycle strip-mined vector ALU (vadd/vsub vv/vx, vslide1up/down)
//
// Purpose: accepts one vector request per handshake, processes LANES elements
// per EXEC cycle over the active length vl, then presents result_v until the
// consumer takes it. Tail (i >= vl) elements keep vector_d.
//
// Optional feature macro: VALU_MASK_EN (adds v0_mask/vm; masked-off active
// elements keep vector_d).
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid / in_ready  request handshake; all inputs latched on acceptance
//   op                   0=SUB 1=ADD 2=SLIDE1UP 3=SLIDE1DOWN, others no-op
//   is_vx                ADD/SUB use scalar_a broadcast instead of vector_a
//   vl                   active element count, clamped to VLMAX
//   scalar_a             scalar operand, low SEW bits used
//   vector_a/b/d         vs1, vs2, old vd
//   v0_mask, vm          (VALU_MASK_EN only) element mask, vm=1 disables masking
//   out_valid/out_ready  result handshake
//   result_v             result vector, retained after the result is taken
//   busy                 high whenever not IDLE
module vector_alu_seq #(
  parameter int VLMAX = 8,
  parameter int SEW   = 32,
  parameter int LANES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   op,
  input  logic                         is_vx,
  input  logic [$clog2(VLMAX+1)-1:0]   vl,
  input  logic [31:0]                  scalar_a,
  input  logic [VLMAX*SEW-1:0]         vector_a,
  input  logic [VLMAX*SEW-1:0]         vector_b,
  input  logic [VLMAX*SEW-1:0]         vector_d,
`ifdef VALU_MASK_EN
  input  logic [VLMAX-1:0]             v0_mask,
  input  logic                         vm,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [VLMAX*SEW-1:0]         result_v,
  output logic                         busy
);

  localparam int VLW = $clog2(VLMAX+1);
  localparam logic [VLW-1:0] VLMAX_W = VLW'(VLMAX);
  localparam logic [VLW-1:0] LANES_W = VLW'(LANES);

  localparam logic [3:0] OP_SUB  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUP  = 4'd2;
  localparam logic [3:0] OP_SDN  = 4'd3;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_n;

  logic [SEW-1:0] a_in [VLMAX];
  logic [SEW-1:0] b_in [VLMAX];
  logic [SEW-1:0] d_in [VLMAX];

  logic [SEW-1:0] a_q [VLMAX];
  logic [SEW-1:0] b_q [VLMAX];
  logic [SEW-1:0] d_q [VLMAX];
  logic [SEW-1:0] res_q [VLMAX];
  logic [SEW-1:0] res_n [VLMAX];

  logic [3:0]     op_q;
  logic           vx_q;
  logic [VLW-1:0] vl_q;
  logic [SEW-1:0] s_q;
  logic [VLW-1:0] base_q;      // first element index of the current slice
`ifdef VALU_MASK_EN
  logic [VLMAX-1:0] mask_q;
  logic             vm_q;
`endif

  logic [VLW-1:0] vl_clamp;
  logic           accept;
  logic           last_slice;
  logic [SEW-1:0] opnd;
  logic           act;

  for (genvar g = 0; g < VLMAX; g++) begin : g_unpack
    assign a_in[g] = vector_a[g*SEW +: SEW];
    assign b_in[g] = vector_b[g*SEW +: SEW];
    assign d_in[g] = vector_d[g*SEW +: SEW];
    assign result_v[g*SEW +: SEW] = res_q[g];
  end

  assign vl_clamp   = (vl > VLMAX_W) ? VLMAX_W : vl;
  assign accept     = in_valid && in_ready;
  // base_q + LANES never exceeds VLMAX, so the sum fits in VLW bits.
  assign last_slice = (base_q + LANES_W) >= vl_q;

  // State register, slice pointer and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      for (int i = 0; i < VLMAX; i++) res_q[i] <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        // Preload old vd so tail elements and an empty vl need no extra work.
        res_q  <= d_in;
        base_q <= '0;
      end else if (state == EXEC) begin
        res_q  <= res_n;
        base_q <= base_q + LANES_W;
      end
    end
  end

  // Operand capture; contents are don't-care until the next acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op;
      vx_q <= is_vx;
      vl_q <= vl_clamp;
      s_q  <= scalar_a[SEW-1:0];
      a_q  <= a_in;
      b_q  <= b_in;
      d_q  <= d_in;
`ifdef VALU_MASK_EN
      mask_q <= v0_mask;
      vm_q   <= vm;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_n = (vl_clamp == '0) ? DONE : EXEC;
      end
      EXEC: begin
        if (last_slice) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Element datapath: every element position is evaluated, but only those
  // inside the current slice are written back.
  always_comb begin
    res_n = res_q;
    opnd  = '0;
    act   = 1'b0;
    for (int i = 0; i < VLMAX; i++) begin
      if (VLW'(i) >= base_q && VLW'(i) < base_q + LANES_W) begin
`ifdef VALU_MASK_EN
        act = vm_q || mask_q[i];
`else
        act = 1'b1;
`endif
        opnd = vx_q ? s_q : a_q[i];
        if (VLW'(i) >= vl_q || !act) begin
          res_n[i] = d_q[i];
        end else begin
          case (op_q)
            OP_SUB:  res_n[i] = b_q[i] - opnd;
            OP_ADD:  res_n[i] = b_q[i] + opnd;
            OP_SUP:  res_n[i] = (i == 0) ? s_q : b_q[(i == 0) ? 0 : i - 1];
            // When i is the last physical element it must be vl-1 here.
            OP_SDN:  res_n[i] = (VLW'(i) == vl_q - VLW'(1)) ? s_q
                                : b_q[(i == VLMAX - 1) ? i : i + 1];
            default: res_n[i] = d_q[i];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_alu_seq.sv
// tb/tb_vector_alu_seq.sv - scoreboard testbench for vector_alu_seq
module tb_vector_alu_seq;
  localparam int VLMAX = 8;
  localparam int SEW   = 32;
  localparam int LANES = 2;
  localparam int W     = VLMAX * SEW;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, is_vx, out_valid, out_ready, busy;
  logic [3:0]   op;
  logic [3:0]   vl;
  logic [31:0]  scalar_a;
  logic [W-1:0] vector_a, vector_b, vector_d, result_v;
`ifdef VALU_MASK_EN
  logic [VLMAX-1:0] v0_mask;
  logic             vm;
`endif

  always #5 clk = ~clk;

  vector_alu_seq #(.VLMAX(VLMAX), .SEW(SEW), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_vx(is_vx), .vl(vl), .scalar_a(scalar_a),
    .vector_a(vector_a), .vector_b(vector_b), .vector_d(vector_d),
`ifdef VALU_MASK_EN
    .v0_mask(v0_mask), .vm(vm),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result_v(result_v), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [W-1:0] mk8(input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [W-1:0] ramp(input int m, input int c);
    logic [W-1:0] r;
    for (int i = 0; i < VLMAX; i++) r[i*32 +: 32] = 32'(m * i + c);
    return r;
  endfunction

  function automatic logic [W-1:0] fill(input logic [31:0] v);
    return {VLMAX{v}};
  endfunction

  // Monitor: samples just after the falling edge, pops on each taken result.
  logic         prev_valid = 1'b0;
  logic [W-1:0] prev_res;
  logic         pop_pending = 1'b0;
  int           first_cyc = 0;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_valid  = 1'b0;
      pop_pending = 1'b0;
    end else begin
      if (pop_pending) begin
        chk("in_ready_after_pop", W'(in_ready), W'(1));
        pop_pending = 1'b0;
      end
      if (out_valid) begin
        if (!prev_valid) first_cyc = cyc;
        else chk("hold_stable", result_v, prev_res);
        if (out_ready) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got %0h expected none", result_v);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, "_res"}, result_v, e.res);
            chk({e.name, "_lat"}, W'(first_cyc - e.acc), W'(e.lat));
            pop_pending = 1'b1;
          end
        end
      end
      prev_valid = out_valid;
      prev_res   = result_v;
    end
  end

  task automatic issue(input string nm, input logic [3:0] o, input logic x, input logic [3:0] l,
                       input logic [31:0] s, input logic [W-1:0] a, b, d,
                       input logic [W-1:0] ex, input int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_issue_timeout: got in_ready=0 expected 1", nm);
      return;
    end
    op = o; is_vx = x; vl = l; scalar_a = s;
    vector_a = a; vector_b = b; vector_d = d;
    in_valid = 1'b1;
    sbq.push_back('{res: ex, lat: lat, acc: cyc, name: nm});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d expected idle", nm, busy, sbq.size());
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_out_valid"}, W'(out_valid), W'(0));
    chk({nm, "_in_ready"},  W'(in_ready),  W'(1));
    chk({nm, "_busy"},      W'(busy),      W'(0));
    chk({nm, "_result"},    result_v,      '0);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; is_vx = 1'b0; vl = '0;
    scalar_a = '0; vector_a = '0; vector_b = '0; vector_d = '0;
`ifdef VALU_MASK_EN
    v0_mask = '0; vm = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    // vv add/sub, full and partial vl
    issue("add_vl8", 4'd1, 1'b0, 4'd8, 32'd0, ramp(1, 0), ramp(10, 0), fill(DB), ramp(11, 0), 5);
    wait_idle("add_vl8");
    issue("add_vl3", 4'd1, 1'b0, 4'd3, 32'd0, ramp(1, 0), ramp(10, 0), fill(DB),
          mk8(0, 11, 22, DB, DB, DB, DB, DB), 3);
    wait_idle("add_vl3");
    issue("sub_vv", 4'd0, 1'b0, 4'd8, 32'd0, ramp(1, 0), ramp(10, 0), fill(DB), ramp(9, 0), 5);
    wait_idle("sub_vv");

    // wrap and scalar broadcast
    issue("sub_wrap", 4'd0, 1'b1, 4'd8, 32'd1, ramp(1, 0), '0, fill(DB), fill(32'hFFFF_FFFF), 5);
    wait_idle("sub_wrap");
    issue("add_wrap", 4'd1, 1'b1, 4'd8, 32'd1, ramp(1, 0), fill(32'hFFFF_FFFF), fill(DB), '0, 5);
    wait_idle("add_wrap");
    issue("add_vx_vl7", 4'd1, 1'b1, 4'd7, 32'd5, ramp(1, 0), ramp(10, 0), fill(DB),
          mk8(5, 15, 25, 35, 45, 55, 65, DB), 5);
    wait_idle("add_vx_vl7");

    // slides
    issue("slide1up", 4'd2, 1'b0, 4'd5, 32'h55, '0, ramp(1, 1), fill(32'hEE),
          mk8(32'h55, 1, 2, 3, 4, 32'hEE, 32'hEE, 32'hEE), 4);
    wait_idle("slide1up");
    issue("slide1down", 4'd3, 1'b0, 4'd5, 32'h55, '0, ramp(1, 1), fill(32'hEE),
          mk8(2, 3, 4, 5, 32'h55, 32'hEE, 32'hEE, 32'hEE), 4);
    wait_idle("slide1down");
    issue("slide1down_vl8", 4'd3, 1'b0, 4'd8, 32'h55, '0, ramp(1, 1), fill(32'hEE),
          mk8(2, 3, 4, 5, 6, 7, 8, 32'h55), 5);
    wait_idle("slide1down_vl8");

    // vl boundaries and unsupported opcode
    issue("vl0", 4'd1, 1'b0, 4'd0, 32'd0, ramp(1, 0), ramp(10, 0), ramp(3, 7), ramp(3, 7), 1);
    wait_idle("vl0");
    issue("vl15", 4'd1, 1'b0, 4'd15, 32'd0, ramp(1, 0), ramp(10, 0), fill(DB), ramp(11, 0), 5);
    wait_idle("vl15");
    issue("noop", 4'd9, 1'b0, 4'd4, 32'd0, ramp(1, 0), ramp(10, 0), ramp(2, 1), ramp(2, 1), 3);
    wait_idle("noop");

    // backpressure: result held, new requests ignored
    out_ready = 1'b0;
    issue("bp", 4'd1, 1'b0, 4'd4, 32'd0, ramp(1, 1), ramp(10, 0),
          fill(DB), mk8(1, 12, 23, 34, DB, DB, DB, DB), 3);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_out_valid", W'(out_valid), W'(1));
      in_valid = 1'b1; op = 4'd0; vl = 4'd8; vector_a = fill(32'h1234);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle("bp");

`ifdef VALU_MASK_EN
    vm = 1'b0;
    v0_mask = 8'b0101_0101;
    issue("mask", 4'd1, 1'b0, 4'd8, 32'd0, ramp(1, 0), ramp(10, 0), fill(DB),
          mk8(0, DB, 22, DB, 44, DB, 66, DB), 5);
    wait_idle("mask");
    vm = 1'b1;
`endif

    // reset in the middle of EXEC discards the request
    issue("abort", 4'd1, 1'b0, 4'd8, 32'd0, ramp(1, 0), ramp(10, 0), fill(DB), ramp(11, 0), 5);
    @(negedge clk);
    chk("abort_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk_reset("abort");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_output", W'(out_valid), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
